// File: rtl/neuron_access_ctrl.sv
// rtl/neuron_access_ctrl.sv - host command port to neuron state memory bridge
// Handles one write/read/enable/disable command at a time; ext_ack wait is bounded by TIMEOUT.
module neuron_access_ctrl #(
  parameter int NEURON_NUMBER = 256,
  parameter int NEUR_WIDTH    = 13,
  parameter int TIMEOUT       = 64,
  parameter int EN_RESET      = 1,
  localparam int AW = (NEURON_NUMBER > 1) ? $clog2(NEURON_NUMBER) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [AW-1:0]         cmd_addr,
  input  logic [NEUR_WIDTH-1:0] cmd_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [NEUR_WIDTH-1:0] rsp_data,
  output logic                  rsp_err,
  output logic                  ext_req,
  input  logic                  ext_ack,
  output logic                  ext_we,
  output logic                  ext_re,
  output logic [AW-1:0]         ext_neur_addr,
  output logic [NEUR_WIDTH-1:0] ext_neur_data_in,
  input  logic [NEUR_WIDTH-1:0] ext_neur_data_out,
  output logic                  sys_en
);

  // Counter holds TIMEOUT itself so it never wraps on the final REQ cycle.
  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WR, S_RD, S_RD_WAIT, S_RSP
  } state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt;
  logic            op_rd;
  logic            accept;
  logic            cnt_last;

  assign accept   = cmd_valid && cmd_ready;
  assign cnt_last = (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    ext_req   = 1'b0;
    ext_we    = 1'b0;
    ext_re    = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = !reset;
        if (cmd_valid) state_nx = cmd_op[1] ? S_RSP : S_REQ;
      end
      S_REQ: begin
        ext_req = 1'b1;
        if (ext_ack)       state_nx = op_rd ? S_RD : S_WR;
        else if (cnt_last) state_nx = S_RSP;
      end
      S_WR: begin
        ext_req  = 1'b1;
        ext_we   = 1'b1;
        state_nx = S_RSP;
      end
      S_RD: begin
        ext_req  = 1'b1;
        ext_re   = 1'b1;
        state_nx = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        ext_req  = 1'b1;
        state_nx = S_RSP;
      end
      S_RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt              <= '0;
      op_rd            <= 1'b0;
      ext_neur_addr    <= '0;
      ext_neur_data_in <= '0;
      rsp_data         <= '0;
      rsp_err          <= 1'b0;
      sys_en           <= (EN_RESET != 0);
    end else begin
      if (accept) begin
        op_rd            <= cmd_op[0];
        ext_neur_addr    <= cmd_addr;
        ext_neur_data_in <= cmd_data;
        cnt              <= '0;
        rsp_data         <= '0;
        rsp_err          <= 1'b0;
        if (cmd_op == 2'b10) sys_en <= 1'b1;
        if (cmd_op == 2'b11) sys_en <= 1'b0;
      end
      if (state == S_REQ) begin
        cnt <= cnt + CW'(1);
        if (!ext_ack && cnt_last) rsp_err <= 1'b1;
      end
      if (state == S_RD_WAIT) rsp_data <= ext_neur_data_out;
    end
  end

endmodule

// File: tb/tb_neuron_access_ctrl.sv
// tb/tb_neuron_access_ctrl.sv - scoreboard bench for neuron_access_ctrl
module tb_neuron_access_ctrl;

  localparam int NN = 256;
  localparam int NW = 13;
  localparam int TO = 64;
  localparam int AW = 8;
  localparam int NEVER = 1000;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = '0;
  logic [AW-1:0] cmd_addr = '0;
  logic [NW-1:0] cmd_data = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [NW-1:0] rsp_data;
  logic          rsp_err;
  logic          ext_req;
  logic          ext_ack = 1'b0;
  logic          ext_we;
  logic          ext_re;
  logic [AW-1:0] ext_neur_addr;
  logic [NW-1:0] ext_neur_data_in;
  logic [NW-1:0] ext_neur_data_out = '0;
  logic          sys_en;

  always #5 clk = ~clk;

  neuron_access_ctrl #(.NEURON_NUMBER(NN), .NEUR_WIDTH(NW), .TIMEOUT(TO), .EN_RESET(1)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .ext_req(ext_req), .ext_ack(ext_ack), .ext_we(ext_we), .ext_re(ext_re),
    .ext_neur_addr(ext_neur_addr), .ext_neur_data_in(ext_neur_data_in),
    .ext_neur_data_out(ext_neur_data_out), .sys_en(sys_en)
  );

  typedef struct {
    logic [NW-1:0] data;
    logic          err;
    logic          sen;
    int            lat;
    int            acc;
    logic [AW-1:0] addr;
    logic [NW-1:0] wdata;
    int            nwe;
    int            nre;
  } exp_t;

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  exp_t          q[$];
  logic [NW-1:0] bus_mem[NN];
  logic [NW-1:0] ref_mem[NN];
  logic          ref_sen = 1'b1;
  int            ack_delay = NEVER;
  bit            ack_tie = 1'b0;
  bit            hold_low = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Neuron memory port: ack after ack_delay cycles of ext_req, read data one cycle after ext_re.
  initial begin
    int            req_cnt;
    logic          s_we, s_re;
    logic [AW-1:0] s_a;
    logic [NW-1:0] s_d;
    req_cnt = 0;
    forever begin
      @(negedge clk);
      s_we = ext_we; s_re = ext_re; s_a = ext_neur_addr; s_d = ext_neur_data_in;
      ext_ack = ext_req ? (req_cnt >= ack_delay) : ack_tie;
      req_cnt = ext_req ? req_cnt + 1 : 0;
      @(posedge clk);
      #1;
      if (s_we) bus_mem[s_a] = s_d;
      if (s_re) ext_neur_data_out = bus_mem[s_a];
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      rsp_ready = hold_low ? 1'b0 : ($urandom_range(0, 2) != 0);
    end
  end

  initial begin
    bit            in_rsp;
    int            n_we, n_re;
    exp_t          cur;
    logic [NW-1:0] held_data;
    logic          held_err;
    in_rsp = 0; n_we = 0; n_re = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        in_rsp = 0; n_we = 0; n_re = 0;
        continue;
      end
      if (ext_we || ext_re) begin
        chk("strobe_exclusive", ext_we && ext_re, 0);
        chk("strobe_needs_req", ext_req, 1);
      end
      if (ext_we) begin
        n_we++;
        if (q.size() != 0) begin
          chk("we_addr", ext_neur_addr, q[0].addr);
          chk("we_data", ext_neur_data_in, q[0].wdata);
        end
      end
      if (ext_re) begin
        n_re++;
        if (q.size() != 0) chk("re_addr", ext_neur_addr, q[0].addr);
      end
      if (rsp_valid) begin
        chk("rsp_cmd_ready_low", cmd_ready, 0);
        chk("rsp_ext_req_low", ext_req, 0);
        if (!in_rsp) begin
          in_rsp = 1;
          chk("rsp_expected", q.size() != 0, 1);
          if (q.size() != 0) begin
            cur = q.pop_front();
            chk("rsp_data", rsp_data, cur.data);
            chk("rsp_err", rsp_err, cur.err);
            chk("rsp_latency", cyc - cur.acc, cur.lat);
            chk("rsp_sys_en", sys_en, cur.sen);
            chk("we_pulses", n_we, cur.nwe);
            chk("re_pulses", n_re, cur.nre);
          end
          held_data = rsp_data;
          held_err  = rsp_err;
        end else begin
          chk("rsp_data_stable", rsp_data, held_data);
          chk("rsp_err_stable", rsp_err, held_err);
        end
        if (rsp_ready) begin
          in_rsp = 0; n_we = 0; n_re = 0;
        end
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [AW-1:0] a, input logic [NW-1:0] d,
                      input int dly);
    exp_t e;
    int   n;
    bit   ok;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d;
    n = 0;
    while (!cmd_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      chk("accept_timeout", cmd_ready, 1);
      cmd_valid = 1'b0;
      return;
    end
    ack_delay = dly;
    ack_tie   = (dly == 0);
    ok = (dly < TO);
    e.data = '0; e.err = 1'b0; e.nwe = 0; e.nre = 0;
    e.addr = a; e.wdata = d; e.acc = cyc;
    case (op)
      2'b10: begin ref_sen = 1'b1; e.lat = 1; end
      2'b11: begin ref_sen = 1'b0; e.lat = 1; end
      2'b00: begin
        if (ok) begin ref_mem[a] = d; e.lat = dly + 3; e.nwe = 1; end
        else    begin e.err = 1'b1; e.lat = TO + 1; end
      end
      default: begin
        if (ok) begin e.data = ref_mem[a]; e.lat = dly + 4; e.nre = 1; end
        else    begin e.err = 1'b1; e.lat = TO + 1; end
      end
    endcase
    e.sen = ref_sen;
    q.push_back(e);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q.size() != 0 || rsp_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain", q.size(), 0);
  endtask

  initial begin
    int dly;
    for (int i = 0; i < NN; i++) begin
      bus_mem[i] = NW'($urandom);
      ref_mem[i] = bus_mem[i];
    end
    bus_mem[8'hFF] = 13'h0123;
    ref_mem[8'hFF] = 13'h0123;

    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_ext_req", ext_req, 0);
    chk("rst_sys_en", sys_en, 1);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_addr", ext_neur_addr, 0);
    chk("rst_wdata", ext_neur_data_in, 0);
    reset = 1'b0;

    send(2'b00, 8'h2A, 13'h1ABC, 0);
    wait_idle();
    send(2'b01, 8'hFF, 13'h0000, 5);
    wait_idle();
    send(2'b01, 8'h10, 13'h0000, NEVER);
    wait_idle();
    send(2'b11, 8'h00, 13'h0000, 0);
    wait_idle();
    send(2'b10, 8'h00, 13'h0000, 0);
    wait_idle();
    send(2'b00, 8'h33, 13'h0555, TO - 1);
    send(2'b01, 8'h33, 13'h0000, TO);
    send(2'b01, 8'h33, 13'h0000, 1);
    wait_idle();

    hold_low = 1'b1;
    send(2'b00, 8'h44, 13'h1234, 0);
    fork
      begin
        int n;
        n = 0;
        while (!rsp_valid && n < 50) begin
          @(negedge clk);
          n++;
        end
        repeat (10) begin
          @(negedge clk);
          chk("bp_rsp_valid", rsp_valid, 1);
          chk("bp_cmd_ready", cmd_ready, 0);
        end
        hold_low = 1'b0;
      end
      send(2'b01, 8'h44, 13'h0000, 0);
    join
    wait_idle();

    send(2'b11, 8'h00, 13'h0000, 0);
    wait_idle();
    send(2'b01, 8'h55, 13'h0000, 2);
    begin
      int n;
      n = 0;
      while (!ext_re && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("mid_re_seen", ext_re, 1);
    end
    @(negedge clk);
    reset = 1'b1;
    q.delete();
    ref_sen = 1'b1;
    @(negedge clk);
    chk("mid_ext_req", ext_req, 0);
    chk("mid_rsp_valid", rsp_valid, 0);
    chk("mid_sys_en", sys_en, 1);
    chk("mid_cmd_ready", cmd_ready, 0);
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("mid_no_rsp", rsp_valid, 0);
    end

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 9))
        6:       dly = 0;
        7:       dly = TO - 1;
        8:       dly = TO;
        9:       dly = NEVER;
        default: dly = $urandom_range(0, 6);
      endcase
      send(2'($urandom_range(0, 3)), AW'($urandom_range(0, 15)), NW'($urandom), dly);
    end
    wait_idle();

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/neuron_access_ctrl.md
NEURON_ACCESS_CTRL -- requirements
Module: neuron_access_ctrl

Interface
REQ-001 Parameters SHALL be:
- NEURON_NUMBER, default 256, neuron count.
- NEUR_WIDTH, default 13, neuron state word width.
- TIMEOUT, default 64, maximum cycles to wait for ext_ack.
- EN_RESET, default 1, sys_en value after reset.
REQ-002 Ports SHALL be (AW = $clog2(NEURON_NUMBER)):
- clk  in  1  sole clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high.
- cmd_valid  in  1  host command present.
- cmd_ready  out  1  controller accepts a command.
- cmd_op  in  2  00 write, 01 read, 10 enable, 11 disable.
- cmd_addr  in  AW  neuron address.
- cmd_data  in  NEUR_WIDTH  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  host consumes the response.
- rsp_data  out  NEUR_WIDTH  read data; 0 for non-read commands.
- rsp_err  out  1  ext_ack timeout occurred.
- ext_req  out  1  request for the neuron memory port.
- ext_ack  in  1  neuron module grants the port.
- ext_we  out  1  one-cycle write strobe.
- ext_re  out  1  one-cycle read strobe.
- ext_neur_addr  out  AW  access address.
- ext_neur_data_in  out  NEUR_WIDTH  write data to the neuron module.
- ext_neur_data_out  in  NEUR_WIDTH  read data, valid one cycle after ext_re.
- sys_en  out  1  neuron update enable.

Function
REQ-003 The FSM SHALL have the states IDLE, REQ, WR, RD, RD_WAIT and RSP, and SHALL process one command at a time.
REQ-004 cmd_ready SHALL be 1 only in IDLE.
REQ-005 A command is accepted on cmd_valid&cmd_ready, which latches op, addr and data into registers.
REQ-006 On accepting op 10 or 11, sys_en SHALL be set to 1 or 0 on the next edge, and the FSM SHALL go directly to RSP with rsp_data=0 and rsp_err=0.
REQ-007 On accepting op 00 or 01, the FSM SHALL go to REQ, clear the timeout counter and assert ext_req from the next cycle.
REQ-008 In REQ:
- ext_req=1 and the counter increments each cycle.
- If ext_ack=1, go to WR (op 00) or RD (op 01).
- Else, if the counter equals TIMEOUT-1, go to RSP with rsp_err=1 and rsp_data=0.
- ext_ack has priority over timeout in the same cycle.
REQ-009 In WR, ext_req=1 and ext_we=1 for exactly one cycle, with ext_neur_addr and ext_neur_data_in driven from the latched registers; then go to RSP with rsp_err=0.
REQ-010 In RD, ext_req=1 and ext_re=1 for exactly one cycle, with ext_neur_addr driven; then go to RD_WAIT.
REQ-011 In RD_WAIT, ext_req=1; ext_neur_data_out is registered into rsp_data; then go to RSP with rsp_err=0.
REQ-012 In RSP:
- rsp_valid=1, and rsp_data/rsp_err are held stable.
- ext_req, ext_we and ext_re are 0.
- Exit to IDLE on rsp_ready=1.
REQ-013 ext_we and ext_re SHALL never both be 1, and SHALL never be 1 while ext_req=0.
REQ-014 ext_neur_addr and ext_neur_data_in SHALL hold their latched values from acceptance until the next acceptance.
REQ-015 sys_en SHALL change only via op 10/11 or reset; read/write accesses leave sys_en unchanged.
REQ-016 Out-of-range addresses (>= NEURON_NUMBER, when NEURON_NUMBER is not a power of 2) SHALL be passed through unchecked.
REQ-017 Latency from acceptance to rsp_valid SHALL be:
- write: 3 cycles with ext_ack already high.
- read: 4 cycles with ext_ack already high.
- enable/disable: 1 cycle.
- timeout: TIMEOUT+1 cycles.

Reset
REQ-018 reset=1 SHALL force, on the next edge:
- state IDLE and counter 0;
- rsp_valid, rsp_err, rsp_data, ext_req, ext_we, ext_re, ext_neur_addr and ext_neur_data_in to 0;
- sys_en to EN_RESET.
REQ-019 Reset asserted mid-access (REQ/WR/RD/RD_WAIT/RSP) SHALL abandon the command with no response; ext_req SHALL be 0 from the cycle after reset.
REQ-020 cmd_ready SHALL be 0 while reset=1.

Verification
REQ-021 The bench SHALL cover:
- Write: op 00, addr 0x2A, data 0x1ABC, ext_ack tied 1 -> one ext_we pulse with addr 0x2A / data 0x1ABC; rsp_valid 3 cycles after acceptance; rsp_err=0.
- Read: op 01, addr 0xFF, model returns 0x0123 one cycle after ext_re, ext_ack delayed 5 cycles -> rsp_data=0x0123 and rsp_err=0.
- Timeout: ext_ack tied 0, op 01, TIMEOUT=64 -> rsp_valid 65 cycles after acceptance; rsp_err=1; no ext_re pulse.
- Enable control: reset -> sys_en=1; op 11 -> sys_en=0 the next cycle; rsp_valid follows; op 10 -> sys_en=1.
- Backpressure: rsp_ready held 0 for 10 cycles -> rsp_valid/rsp_data stable; cmd_ready=0 throughout; a queued cmd_valid is accepted only after IDLE is re-entered.
- Reset mid-access: reset pulsed in RD_WAIT -> no rsp_valid; ext_req=0 the next cycle; sys_en=EN_RESET.
